// File: rtl/oflow_seq_pkg.sv
// Shared definitions for the optical-flow set sequencer.
// Holds the sequencer state encoding and the sizing constants used by the
// top level and by the PE mask generator.
package oflow_seq_pkg;

  localparam int PE_NUM          = 24;    // PEs per set
  localparam int SET_LEN         = 8;     // width of set counters
  localparam int REMAIN_BBOX_LEN = 10;    // width of remaining-bbox count
  localparam int TIMEOUT_CYC     = 1024;  // RUN cycles allowed before abort
  localparam int TMO_W           = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SET = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/oflow_pe_mask_gen.sv
// Combinational active-PE mask generator.
// A PE is enabled when its index is below the number of bboxes still to be
// dispatched; with PE_NUM or more bboxes left every PE is enabled.
// Ports:
//   remain  in   REMAIN_BBOX_LEN  bboxes not yet dispatched
//   mask    out  PE_NUM           one bit per PE, low bits filled first
module oflow_pe_mask_gen
  import oflow_seq_pkg::*;
(
  input  logic [REMAIN_BBOX_LEN-1:0] remain,
  output logic [PE_NUM-1:0]          mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      mask[i] = (remain > REMAIN_BBOX_LEN'(i));
    end
  end

endmodule

// File: rtl/oflow_set_sequencer.sv
// Per-frame set sequencer between the core top FSM and the PE array.
// A frame starts on start_pe; for each set the block waits for the DMA
// (new_set), enables the PEs that have bboxes, pulses pe_start, gathers the
// per-PE done bits and counts the set. After the last set done_pe pulses.
// A set that stays in RUN for TIMEOUT_CYC cycles is aborted and flagged.
//
// Handshake: new_set is a level, consumed on the cycle it is sampled in
// WAIT_SET; pe_start is a one-cycle pulse the cycle after that; pe_done bits
// are pulses, each accepted only in RUN and only inside pe_enable; done_pe is
// a one-cycle pulse issued the cycle after the final counter update.
//
// Ports:
//   clk, reset                in   clock, synchronous active-high reset
//   start_pe                  in   pulse: begin frame (honoured only in IDLE)
//   num_of_sets               in   sets in frame, sampled with start_pe
//   counter_of_remain_bboxes  in   bboxes not yet dispatched
//   new_set                   in   level: DMA set available
//   pe_done                   in   per-PE done pulses
//   pe_start                  out  pulse: PE array starts current set
//   pe_enable                 out  active-PE mask for current set
//   counter_set_fe            out  sets completed in this frame
//   done_pe                   out  pulse: all sets of the frame done
//   busy                      out  high in any non-IDLE state
//   err_timeout               out  sticky timeout flag, cleared by start_pe
module oflow_set_sequencer
  import oflow_seq_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_pe,
  input  logic [SET_LEN-1:0]         num_of_sets,
  input  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
  input  logic                       new_set,
  input  logic [PE_NUM-1:0]          pe_done,
  output logic                       pe_start,
  output logic [PE_NUM-1:0]          pe_enable,
  output logic [SET_LEN-1:0]         counter_set_fe,
  output logic                       done_pe,
  output logic                       busy,
  output logic                       err_timeout
);

  seq_state_t          state_q, state_d;
  logic [SET_LEN-1:0]  sets_total_q, sets_total_d;
  logic [SET_LEN-1:0]  counter_q, counter_d, counter_inc;
  logic [PE_NUM-1:0]   pe_enable_q, pe_enable_d;
  logic [PE_NUM-1:0]   done_seen_q, done_seen_d, seen_now;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                pe_start_q, pe_start_d;
  logic                done_pe_q, done_pe_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [PE_NUM-1:0]   set_mask;

  oflow_pe_mask_gen u_mask_gen (
    .remain (counter_of_remain_bboxes),
    .mask   (set_mask)
  );

  assign counter_inc = counter_q + SET_LEN'(1);
  // Done bits gathered so far plus the ones arriving this cycle; stray bits
  // outside the active mask never contribute.
  assign seen_now    = done_seen_q | (pe_done & pe_enable_q);

  always_comb begin
    state_d      = state_q;
    sets_total_d = sets_total_q;
    counter_d    = counter_q;
    pe_enable_d  = pe_enable_q;
    done_seen_d  = done_seen_q;
    tmo_d        = tmo_q;
    pe_start_d   = 1'b0;
    done_pe_d    = 1'b0;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (start_pe) begin
          sets_total_d = num_of_sets;
          counter_d    = '0;
          err_d        = 1'b0;
          state_d      = (num_of_sets == '0) ? DONE : WAIT_SET;
        end
      end

      WAIT_SET: begin
        if (new_set) begin
          pe_enable_d = set_mask;
          if (set_mask == '0) begin
            // Nothing to compute: the set counts as complete right away.
            counter_d = counter_inc;
            state_d   = (counter_inc == sets_total_q) ? DONE : WAIT_SET;
          end else begin
            pe_start_d  = 1'b1;
            done_seen_d = '0;
            tmo_d       = '0;
            state_d     = RUN;
          end
        end
      end

      RUN: begin
        done_seen_d = seen_now;
        if (seen_now == pe_enable_q) begin
          counter_d = counter_inc;
          state_d   = (counter_inc == sets_total_q) ? DONE : WAIT_SET;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          // Completion wins if it lands on the final allowed cycle.
          err_d       = 1'b1;
          pe_enable_d = '0;
          state_d     = DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      DONE: begin
        done_pe_d   = 1'b1;
        pe_enable_d = '0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sets_total_q <= '0;
      counter_q    <= '0;
      pe_enable_q  <= '0;
      done_seen_q  <= '0;
      tmo_q        <= '0;
      pe_start_q   <= 1'b0;
      done_pe_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sets_total_q <= sets_total_d;
      counter_q    <= counter_d;
      pe_enable_q  <= pe_enable_d;
      done_seen_q  <= done_seen_d;
      tmo_q        <= tmo_d;
      pe_start_q   <= pe_start_d;
      done_pe_q    <= done_pe_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign pe_start       = pe_start_q;
  assign pe_enable      = pe_enable_q;
  assign counter_set_fe = counter_q;
  assign done_pe        = done_pe_q;
  assign busy           = busy_q;
  assign err_timeout    = err_q;

endmodule
